// File: rtl/ltc2387_pkg.sv
// ltc2387_pkg: shared types and constants for the LTC2387 digital-port emulator.
//   state_e          : emulator state (IDLE / CONVERT / READY)
//   ADC_WIDTH_DEFAULT: default sample width in bits
//   LANES_ONE/TWO    : lane-count constants
//   conv_cycles()    : ceil(ns * freq / 1e9), conversion time in clock cycles
package ltc2387_pkg;

   localparam int ADC_WIDTH_DEFAULT = 18;
   localparam int LANES_ONE         = 1;
   localparam int LANES_TWO         = 2;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CONVERT = 2'd1,
      ST_READY   = 2'd2
   } state_e;

   // Integer ceiling of ns*freq/1e9. Done in 64 bits because the product
   // overflows 32 bits at typical clock rates.
   function automatic int conv_cycles(input longint freq, input longint ns);
      longint prod;
      prod = freq * ns;
      return int'((prod + longint'(999_999_999)) / longint'(1_000_000_000));
   endfunction

endpackage

// File: rtl/ltc2387_sync.sv
// ltc2387_sync: N-stage synchronizer with rising/falling edge detection.
//   clk_i  : sampling clock
//   srst_i : synchronous active-high reset (clears all stages)
//   d_i    : asynchronous input
//   q_o    : synchronized level (last stage)
//   rise_o : high for one cycle when q_o has just gone 0->1
//   fall_o : high for one cycle when q_o has just gone 1->0
module ltc2387_sync #(
   parameter int STAGES = 2
) (
   input  logic clk_i,
   input  logic srst_i,
   input  logic d_i,
   output logic q_o,
   output logic rise_o,
   output logic fall_o
);

   logic [STAGES-1:0] sync_q;
   logic              last_q;

   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         sync_q <= '0;
         last_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d_i};
         last_q <= sync_q[STAGES-1];
      end
   end

   assign q_o    = sync_q[STAGES-1];
   assign rise_o = sync_q[STAGES-1] & ~last_q;
   assign fall_o = ~sync_q[STAGES-1] & last_q;

endmodule

// File: rtl/ltc2387_emulator.sv
// ltc2387_emulator: FPGA-side model of the LTC2387 digital output port.
// A cnv rising edge latches a sample, waits the conversion time, then shifts
// the sample out MSB-first on da/db, one bit (one-lane) or bit pair
// (two-lane) per clk edge, both edges counting.
//   sys_clk_int : system clock, all logic on its rising edge
//   reset_int   : synchronous active-high reset
//   cnv         : conversion start (synchronous)
//   clk         : gated ADC data clock (asynchronous, synchronized here)
//   tl          : 1 = two-lane, 0 = one-lane (sampled at conversion start)
//   sample_in   : sample value (latched at conversion start)
//   dco         : synchronized echo of clk
//   da, db      : lane A / lane B data
//   busy        : conversion or readout in progress
//   abort_pulse : one-cycle pulse when a readout is cut short by a new cnv
// Build option: define LTC2387_EMU_RAMP_EN to replace sample_in with an
// internal counter that increments on every conversion start.
module ltc2387_emulator
   import ltc2387_pkg::*;
#(
   parameter int ADC_WIDTH    = ADC_WIDTH_DEFAULT,
   parameter int SYS_CLK_FREQ = 200_000_000,
   parameter int T_CONV_NS    = 65,
   parameter int SYNC_STAGES  = 2
) (
   input  logic                 sys_clk_int,
   input  logic                 reset_int,
   input  logic                 cnv,
   input  logic                 clk,
   input  logic                 tl,
   input  logic [ADC_WIDTH-1:0] sample_in,
   output logic                 dco,
   output logic                 da,
   output logic                 db,
   output logic                 busy,
   output logic                 abort_pulse
);

   localparam int CONV_CYCLES = conv_cycles(longint'(SYS_CLK_FREQ), longint'(T_CONV_NS));
   localparam int CNT_MAX     = (CONV_CYCLES > ADC_WIDTH) ? CONV_CYCLES : ADC_WIDTH;
   localparam int CNT_W       = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] CONV_LAST     = CNT_W'(CONV_CYCLES - 1);
   localparam logic [CNT_W-1:0] LAST_EDGE_TWO = CNT_W'(ADC_WIDTH / LANES_TWO - 1);
   localparam logic [CNT_W-1:0] LAST_EDGE_ONE = CNT_W'(ADC_WIDTH / LANES_ONE - 1);

   state_e                 state_q;
   logic [CNT_W-1:0]       cnt_q;
   logic [ADC_WIDTH-1:0]   sr_q;
   logic                   tl_q;
   logic                   cnv_q;
   logic                   dco_q;
   logic                   edge_q;
   logic                   da_q;
   logic                   db_q;
   logic                   busy_q;
   logic                   abort_q;

   logic                   clk_sync;
   logic                   clk_rise;
   logic                   clk_fall;
   logic                   start;
   logic [CNT_W-1:0]       last_edge;
   logic [ADC_WIDTH-1:0]   sample_src;

   ltc2387_sync #(
      .STAGES (SYNC_STAGES)
   ) u_clk_sync (
      .clk_i  (sys_clk_int),
      .srst_i (reset_int),
      .d_i    (clk),
      .q_o    (clk_sync),
      .rise_o (clk_rise),
      .fall_o (clk_fall)
   );

   assign start     = cnv & ~cnv_q;
   assign last_edge = tl_q ? LAST_EDGE_TWO : LAST_EDGE_ONE;

`ifdef LTC2387_EMU_RAMP_EN
   logic [ADC_WIDTH-1:0] ramp_q;
   logic [ADC_WIDTH-1:0] unused_sample_in;

   assign unused_sample_in = sample_in;

   // Advances on every start, including one that aborts a readout.
   always_ff @(posedge sys_clk_int) begin
      if (reset_int) begin
         ramp_q <= '0;
      end else if (start) begin
         ramp_q <= ramp_q + 1'b1;
      end
   end

   assign sample_src = ramp_q;
`else
   assign sample_src = sample_in;
`endif

   always_ff @(posedge sys_clk_int) begin
      if (reset_int) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         sr_q    <= '0;
         tl_q    <= 1'b0;
         cnv_q   <= 1'b0;
         dco_q   <= 1'b0;
         edge_q  <= 1'b0;
         da_q    <= 1'b0;
         db_q    <= 1'b0;
         busy_q  <= 1'b0;
         abort_q <= 1'b0;
      end else begin
         cnv_q   <= cnv;
         dco_q   <= clk_sync;
         abort_q <= 1'b0;
         // Only edges detected while already in READY, and not coinciding
         // with a start, are acted on one cycle later. This delays the data
         // advance one cycle behind dco so data is stable across each
         // dco transition.
         edge_q  <= (clk_rise | clk_fall) & (state_q == ST_READY) & ~start;

         if (start) begin
            sr_q    <= sample_src;
            tl_q    <= tl;
            cnt_q   <= '0;
            state_q <= ST_CONVERT;
            busy_q  <= 1'b1;
            da_q    <= 1'b0;
            db_q    <= 1'b0;
            abort_q <= (state_q == ST_READY);
         end else begin
            unique case (state_q)
               ST_CONVERT: begin
                  if (cnt_q == CONV_LAST) begin
                     state_q <= ST_READY;
                     cnt_q   <= '0;
                     da_q    <= sr_q[ADC_WIDTH-1];
                     db_q    <= tl_q & sr_q[ADC_WIDTH-2];
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
               ST_READY: begin
                  if (edge_q) begin
                     if (cnt_q == last_edge) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        da_q    <= 1'b0;
                        db_q    <= 1'b0;
                     end else begin
                        cnt_q <= cnt_q + 1'b1;
                        if (tl_q) begin
                           sr_q <= sr_q << 2;
                           da_q <= sr_q[ADC_WIDTH-3];
                           db_q <= sr_q[ADC_WIDTH-4];
                        end else begin
                           sr_q <= sr_q << 1;
                           da_q <= sr_q[ADC_WIDTH-2];
                           db_q <= 1'b0;
                        end
                     end
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

   assign dco         = dco_q;
   assign da          = da_q;
   assign db          = db_q;
   assign busy        = busy_q;
   assign abort_pulse = abort_q;

endmodule

// File: tb/tb_ltc2387_emulator.sv
module tb_ltc2387_emulator;
   import ltc2387_pkg::*;

   localparam int W    = 18;
   localparam int CONV = 13;

   logic          sys_clk_int = 1'b0;
   logic          reset_int;
   logic          cnv;
   logic          clk;
   logic          tl;
   logic [W-1:0]  sample_in;
   logic          dco;
   logic          da;
   logic          db;
   logic          busy;
   logic          abort_pulse;

   ltc2387_emulator #(
      .ADC_WIDTH    (W),
      .SYS_CLK_FREQ (200_000_000),
      .T_CONV_NS    (65),
      .SYNC_STAGES  (2)
   ) dut (
      .sys_clk_int (sys_clk_int),
      .reset_int   (reset_int),
      .cnv         (cnv),
      .clk         (clk),
      .tl          (tl),
      .sample_in   (sample_in),
      .dco         (dco),
      .da          (da),
      .db          (db),
      .busy        (busy),
      .abort_pulse (abort_pulse)
   );

   always #5 sys_clk_int = ~sys_clk_int;

   typedef struct packed {
      logic [W-1:0] word;
      logic         two_lane;
      logic [7:0]   skip;
      logic         aborts;
   } exp_t;

   exp_t         exp_q[$];
   int           n_cmp = 0;
   int           n_bad = 0;
   logic [W-1:0] ramp_m = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   task automatic fail_now(input string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: event with no matching expectation", name);
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge sys_clk_int);
         #1;
      end
   endtask

   // Drives a one-cycle cnv pulse and queues the readout expected from it.
   task automatic start_conv(input logic [W-1:0] s, input logic t, input int skip,
                             input logic aborts, output logic [W-1:0] w);
      exp_t e;
`ifdef LTC2387_EMU_RAMP_EN
      w      = ramp_m;
      ramp_m = ramp_m + 1'b1;
`else
      w      = s;
`endif
      e.word     = w;
      e.two_lane = t;
      e.skip     = 8'(skip);
      e.aborts   = aborts;
      exp_q.push_back(e);
      $display("cnv: sample_in=0x%05h tl=%0d expect=0x%05h", s, t, w);
      sample_in = s;
      tl        = t;
      cnv       = 1'b1;
      cyc(1);
      cnv       = 1'b0;
   endtask

   task automatic clk_edges(input int n);
      repeat (n) begin
         clk = ~clk;
         cyc(4);
      end
   endtask

   task automatic full_read(input logic [W-1:0] s, input logic t);
      logic [W-1:0] w;
      start_conv(s, t, 0, 1'b0, w);
      cyc(14);
      clk_edges(t ? W / 2 : W);
      cyc(3);
   endtask

   // Monitor: reconstructs each readout from da/db at dco transitions and
   // compares against the head of the expectation queue.
   initial begin
      logic         prev_dco;
      logic         prev_busy;
      logic [W-1:0] acc;
      logic         db_seen;
      int           n_seen;
      int           n_edge;
      exp_t         e;
      prev_dco  = 1'b0;
      prev_busy = 1'b0;
      acc       = '0;
      db_seen   = 1'b0;
      n_seen    = 0;
      n_edge    = 0;
      forever begin
         @(negedge sys_clk_int);
         if (reset_int === 1'b1) begin
            acc = '0; db_seen = 1'b0; n_seen = 0; n_edge = 0;
         end else if (abort_pulse === 1'b1) begin
            if (exp_q.size() == 0) begin
               fail_now("abort_unexpected");
            end else begin
               e = exp_q.pop_front();
               $display("abort: dropped readout of 0x%05h after %0d edges", e.word, n_edge);
               check("abort_expected", 32'(e.aborts), 32'd1);
            end
            acc = '0; db_seen = 1'b0; n_seen = 0; n_edge = 0;
         end else if (prev_busy === 1'b1 && busy === 1'b0) begin
            if (exp_q.size() == 0) begin
               fail_now("readout_unexpected");
            end else begin
               e = exp_q.pop_front();
               $display("readout: tl=%0d word=0x%05h edges=%0d (expect 0x%05h)",
                        e.two_lane, acc, n_edge, e.word);
               check("readout_word", 32'(acc), 32'(e.word));
               check("readout_edges", 32'(n_edge), e.two_lane ? 32'(W / 2) : 32'(W));
               check("readout_not_aborted", 32'(e.aborts), 32'd0);
               if (!e.two_lane) check("one_lane_db_zero", 32'(db_seen), 32'd0);
            end
            acc = '0; db_seen = 1'b0; n_seen = 0; n_edge = 0;
         end else if (busy === 1'b1 && dco !== prev_dco && exp_q.size() > 0) begin
            n_seen++;
            if (n_seen > int'(exp_q[0].skip)) begin
               n_edge++;
               if (exp_q[0].two_lane) begin
                  acc = {acc[W-3:0], da, db};
               end else begin
                  acc     = {acc[W-2:0], da};
                  db_seen = db_seen | db;
               end
            end
         end
         prev_dco  = dco;
         prev_busy = busy;
      end
   end

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] w;
      reset_int = 1'b1;
      cnv       = 1'b0;
      clk       = 1'b0;
      tl        = 1'b0;
      sample_in = '0;
      cyc(3);
      @(negedge sys_clk_int);
      check("por_dco", 32'(dco), 0);
      check("por_da", 32'(da), 0);
      check("por_db", 32'(db), 0);
      check("por_busy", 32'(busy), 0);
      check("por_abort", 32'(abort_pulse), 0);
      cyc(1);
      reset_int = 1'b0;
      cyc(3);

      // Reset in the middle of a readout.
      start_conv(18'h12345, 1'b1, 0, 1'b0, w);
      cyc(14);
      clk_edges(4);
      @(negedge sys_clk_int);
      check("rst_busy_before", 32'(busy), 1);
      cyc(1);
      reset_int = 1'b1;
      exp_q.delete();
      ramp_m = '0;
      cyc(1);
      @(negedge sys_clk_int);
      check("rst_dco", 32'(dco), 0);
      check("rst_da", 32'(da), 0);
      check("rst_db", 32'(db), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_abort", 32'(abort_pulse), 0);
      check("rst_state", 32'(dut.state_q), 32'(ST_IDLE));
      cyc(1);
      reset_int = 1'b0;
      cyc(4);

      // Two-lane 0x2AAAA with conversion and busy timing boundaries.
      @(negedge sys_clk_int);
      check("tl2_busy_before_start", 32'(busy), 0);
      start_conv(18'h2AAAA, 1'b1, 0, 1'b0, w);
      @(negedge sys_clk_int);
      check("tl2_busy_at_c1", 32'(busy), 1);
      cyc(12);
      @(negedge sys_clk_int);
      check("tl2_da_before_ready", 32'(da), 0);
      check("tl2_db_before_ready", 32'(db), 0);
      cyc(1);
      @(negedge sys_clk_int);
      check("tl2_msb_da", 32'(da), 32'(w[W-1]));
      check("tl2_msb_db", 32'(db), 32'(w[W-2]));
      clk_edges(8);
      clk = ~clk;
      cyc(3);
      @(negedge sys_clk_int);
      check("tl2_busy_last_edge_p1", 32'(busy), 1);
      cyc(1);
      @(negedge sys_clk_int);
      check("tl2_busy_last_edge_p2", 32'(busy), 0);
      check("tl2_da_idle", 32'(da), 0);
      cyc(4);
      // Extra edges after the readout must not restart anything.
      clk_edges(2);
      check("tl2_busy_after_extra", 32'(busy), 0);

      // One-lane 0x3C00F.
      full_read(18'h3C00F, 1'b0);
      cyc(2);

      // Abort after 4 edges by a new start with 0x00001.
      start_conv(18'h3FFFF, 1'b1, 0, 1'b1, w);
      cyc(14);
      clk_edges(4);
      start_conv(18'h00001, 1'b1, 0, 1'b0, w);
      @(negedge sys_clk_int);
      check("abort_pulse_high", 32'(abort_pulse), 1);
      check("abort_busy_held", 32'(busy), 1);
      cyc(1);
      @(negedge sys_clk_int);
      check("abort_pulse_one_cycle", 32'(abort_pulse), 0);
      cyc(12);
      clk_edges(9);
      cyc(3);

      // Three clk edges during CONVERT are ignored.
      start_conv(18'h1B3C5, 1'b1, 3, 1'b0, w);
      clk_edges(3);
      cyc(3);
      clk_edges(9);
      cyc(3);

`ifdef LTC2387_EMU_RAMP_EN
      // Ramp source: 0, 1, 2 after reset, then wrap from 0x3FFFF.
      reset_int = 1'b1;
      exp_q.delete();
      ramp_m = '0;
      cyc(2);
      reset_int = 1'b0;
      cyc(6);
      full_read(18'h2AAAA, 1'b1);
      full_read(18'h2AAAA, 1'b1);
      full_read(18'h2AAAA, 1'b0);
      force dut.ramp_q = 18'h3FFFF;
      cyc(1);
      release dut.ramp_q;
      ramp_m = 18'h3FFFF;
      cyc(1);
      full_read(18'h15555, 1'b1);
      full_read(18'h15555, 1'b1);
`endif

      cyc(10);
      check("queue_drained", 32'(exp_q.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ltc2387_emulator.md
# ltc2387_emulator

Synthesizable FPGA-side model of the LTC2387 ADC's digital port: responds to `cnv`/`clk` from the ADC interface and drives `dco`, `da`, `db` with a latched 18-bit sample. Used for loopback bring-up and hardware-in-the-loop testing of the capture path without a physical ADC, on the same board clock as the capture logic.

## Interface
- `ADC_WIDTH`, 18, sample width; must be even.
- `SYS_CLK_FREQ`, 200_000_000, `sys_clk_int` frequency in Hz.
- `T_CONV_NS`, 65, conversion time from `cnv` to first data valid.
- `SYNC_STAGES`, 2, synchronizer depth for `clk`; minimum 2.

Ports:
- `sys_clk_int` in 1: the single clock; all logic on its rising edge.
- `reset_int` in 1: synchronous reset, active-high.
- `cnv` in 1: conversion start from the interface, synchronous to `sys_clk_int`.
- `clk` in 1: gated ADC data clock, asynchronous.
- `tl` in 1: 1 = two-lane, 0 = one-lane; sampled at conversion start.
- `sample_in` in ADC_WIDTH: sample value, latched at conversion start.
- `dco` out 1: data clock echo.
- `da` out 1: lane A (odd bits in two-lane, all bits in one-lane).
- `db` out 1: lane B (even bits; held 0 in one-lane).
- `busy` out 1: conversion or readout in progress.
- `abort_pulse` out 1: one-cycle pulse when a readout is cut short by a new `cnv`.

## Operation
- Constant `CONV_CYCLES = ceil(T_CONV_NS*SYS_CLK_FREQ/1e9)`; 13 at defaults.
- `EDGES = ADC_WIDTH/2` in two-lane mode (9), `ADC_WIDTH` in one-lane mode (18). Every `clk` edge, rising and falling, counts as one edge.
- States:
  - IDLE: `busy`=0; `da`/`db`=0.
  - CONVERT: count `CONV_CYCLES`, then go to READY.
  - READY: shift bits out; count `clk` edges.
- Conversion start is a `cnv` rising edge (`cnv`=1, registered `cnv`=0). It is detected in any state.
  - Latch `sample_in` and `tl`.
  - Enter CONVERT with the counter cleared.
  - If the start arrives in CONVERT or READY, the readout restarts. If it arrives in READY, also pulse `abort_pulse`.
- Entering READY: present the MSB pair. Two-lane: `da`=D17, `db`=D16. One-lane: `da`=D17, `db`=0.
- Two-lane order: D17/D16, D15/D14, …, D1/D0. One-lane order: D17 … D0 on `da`.
- `clk` edges seen in IDLE or CONVERT are ignored; they do not count.
- After edge number `EDGES`: `da`/`db` go to 0, state returns to IDLE, `busy`=0. Further edges are ignored.
- `dco` always mirrors the synchronized `clk`, in every state.
- Reset values: all outputs 0, state IDLE, counters 0, latched sample 0. Reset mid-readout aborts immediately with no `abort_pulse`.

## Timing
- Start detected in cycle c: `busy`=1 from c+1.
- READY is entered and the MSB pair appears on `da`/`db` at c+1+`CONV_CYCLES`.
- Edge detection: `clk` passes through `SYNC_STAGES` flops, then an edge detector. An edge detected in cycle e gives:
  - `dco` update at e+1;
  - data advance to the next bit or pair at e+2.
  Data is therefore stable for one full cycle around every `dco` transition.
- After the final edge at e: data goes to 0 and `busy` falls at e+2.
- Start and `clk` edge in the same cycle: the start wins; the edge is ignored.
- Minimum `clk` half-period the block tracks: 3 `sys_clk_int` cycles.

## Configuration
- Macro: `LTC2387_EMU_RAMP_EN`.
- Defined:
  - `sample_in` is ignored.
  - The sample comes from an internal ADC_WIDTH counter: 0 after reset, +1 on each conversion start, wraps from 0x3FFFF to 0.
  - A start that aborts a readout still advances the counter.
- Undefined: the sample is `sample_in`; no counter logic is built.

## Structure
- Package `ltc2387_pkg`:
  - state enum (IDLE/CONVERT/READY);
  - default `ADC_WIDTH`;
  - a `conv_cycles(freq, ns)` ceiling function;
  - lane-count constants.
- Sub-module `ltc2387_sync`: parameterized N-stage synchronizer with rising/falling edge outputs. Used for `clk`.

## Test plan
- Reset: assert `reset_int` mid-readout. Next cycle: `dco`/`da`/`db`/`busy`/`abort_pulse`=0 and state IDLE.
- Two-lane: `sample_in`=0x2AAAA, `tl`=1, `cnv` pulse, then 9 `clk` edges.
  - Lane A samples at `dco` edges are all 1s; lane B all 0s.
  - The reconstructed word is 0x2AAAA.
  - `busy` spans from c+1 to the last edge+2.
- One-lane: `sample_in`=0x3C00F, `tl`=0, 18 edges.
  - `da` carries 11_1100_0000_0000_1111 MSB-first.
  - `db` stays 0.
- Abort: new `cnv` after 4 edges, `sample_in`=0x00001.
  - `abort_pulse` high for one cycle.
  - The MSB pair reappears after `CONV_CYCLES`.
  - The readout yields 0x00001.
- Early clk: 3 edges during CONVERT are ignored; the following 9 edges deliver the full word unchanged.
- With `LTC2387_EMU_RAMP_EN`: 3 conversions read 0, 1, 2. After forcing the counter to 0x3FFFF, the next two read 0x3FFFF then 0.
